// File: rtl/booth4_pp_stage.sv
// Registered radix-4 Booth encoder and partial-product generator with a
// valid/ready handshake, registered in_ready and a one-entry skid register.
module booth4_pp_stage #(
  parameter int PP_W = 18,
  parameter int PP_N = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            x_i,
  input  logic [16:0]            inv_x_i,
  input  logic [15:0]            y_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PP_W*PP_N-1:0]   pp_o
);

  localparam int SET_W = PP_W * PP_N;

  // inv_x_i is already the exact negation, so no +1 correction row is needed.
  function automatic logic [PP_W-1:0] booth_pp(
    input logic [2:0]  trip,
    input logic [15:0] x,
    input logic [16:0] nx
  );
    logic [PP_W-1:0] r;
    case (trip)
      3'b001, 3'b010: r = {{(PP_W-16){x[15]}}, x};
      3'b011:         r = {{(PP_W-17){x[15]}}, x, 1'b0};
      3'b100:         r = {{(PP_W-18){nx[16]}}, nx, 1'b0};
      3'b101, 3'b110: r = {{(PP_W-17){nx[16]}}, nx};
      default:        r = {PP_W{1'b0}};
    endcase
    return r;
  endfunction

  logic [16:0]      y_ext_s;
  logic [SET_W-1:0] new_pp_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             main_valid_n_s;
  logic             main_load_s;
  logic             main_from_skid_s;
  logic             skid_valid_n_s;
  logic             skid_load_s;

  logic             main_valid_r;
  logic [SET_W-1:0] main_pp_r;
  logic             skid_valid_r;
  logic [SET_W-1:0] skid_pp_r;
  logic             in_ready_r;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = main_valid_r & out_ready;

  // Booth-encode each overlapping multiplier triplet into one partial product.
  always_comb begin
    y_ext_s  = {y_i, 1'b0};
    new_pp_s = {SET_W{1'b0}};
    for (int k = 0; k < PP_N; k++) begin
      new_pp_s[PP_W*k +: PP_W] = booth_pp(y_ext_s[2*k +: 3], x_i, inv_x_i);
    end
  end

  // Steer accepted data into main or skid, and refill main from skid on a drain.
  always_comb begin
    main_valid_n_s   = main_valid_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_valid_n_s   = skid_valid_r;
    skid_load_s      = 1'b0;
    if (out_fire_s) begin
      if (skid_valid_r) begin
        main_from_skid_s = 1'b1;
        skid_valid_n_s   = 1'b0;
      end else if (in_fire_s) begin
        main_load_s = 1'b1;
      end else begin
        main_valid_n_s = 1'b0;
      end
    end else if (in_fire_s) begin
      if (main_valid_r) begin
        skid_load_s    = 1'b1;
        skid_valid_n_s = 1'b1;
      end else begin
        main_load_s    = 1'b1;
        main_valid_n_s = 1'b1;
      end
    end else begin
      main_valid_n_s = main_valid_r;
      skid_valid_n_s = skid_valid_r;
    end
  end

  // Main output register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      main_valid_r <= 1'b0;
      main_pp_r    <= {SET_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_n_s;
      if (main_from_skid_s) begin
        main_pp_r <= skid_pp_r;
      end else if (main_load_s) begin
        main_pp_r <= new_pp_s;
      end
    end
  end

  // Skid register; in_ready is simply "skid will be empty next cycle".
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      skid_valid_r <= 1'b0;
      skid_pp_r    <= {SET_W{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_n_s;
      in_ready_r   <= ~skid_valid_n_s;
      if (skid_load_s) begin
        skid_pp_r <= new_pp_s;
      end
    end
  end

  assign out_valid = main_valid_r;
  assign pp_o      = main_pp_r;
  assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_booth4_pp_stage.sv
// Self-checking bench for booth4_pp_stage: a negedge scoreboard checks every
// output transfer and stall stability; scenario tasks add targeted checks.
module tb_booth4_pp_stage;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  x_i;
  logic [16:0]  inv_x_i;
  logic [15:0]  y_i;
  logic         out_valid;
  logic         out_ready;
  logic [143:0] pp_o;

  typedef struct packed {
    logic [143:0]       pp;
    logic signed [63:0] prod;
  } exp_t;

  exp_t         exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic         stall_v = 1'b0;
  logic [143:0] stall_pp = '0;

  booth4_pp_stage #(.PP_W(18), .PP_N(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_i      (x_i),
    .inv_x_i  (inv_x_i),
    .y_i      (y_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pp_o     (pp_o)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Each partial product is digit*X with digit = y[2k-1] + y[2k] - 2*y[2k+1].
  function automatic logic [143:0] model_pp(input logic [15:0] x, input logic [15:0] y);
    logic [16:0]  ye;
    logic [143:0] r;
    int           d;
    int           v;
    ye = {y, 1'b0};
    r  = '0;
    for (int k = 0; k < 8; k++) begin
      d = int'(ye[2*k]) + int'(ye[2*k+1]) - 2 * int'(ye[2*k+2]);
      v = d * int'($signed(x));
      r[18*k +: 18] = v[17:0];
    end
    return r;
  endfunction

  function automatic logic signed [63:0] wsum(input logic [143:0] pp);
    logic signed [63:0] s;
    s = 64'sd0;
    for (int k = 0; k < 8; k++) begin
      s = s + longint'($signed(pp[18*k +: 18])) * (longint'(1) << (2*k));
    end
    return s;
  endfunction

  task automatic drive(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] xe;
    xe      = {x[15], x};
    x_i     = x;
    inv_x_i = -xe;
    y_i     = y;
  endtask

  // Scoreboard: compare outputs at transfer, check hold while stalled, record inputs.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      exp_q.delete();
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        vectors++;
        if (out_valid !== 1'b1 || pp_o !== stall_pp) begin
          miscompares++;
          $display("FAIL hold: out_valid=%b pp_o=%h, required 1 and %h", out_valid, pp_o, stall_pp);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious: pp_o=%h delivered with nothing outstanding", pp_o);
        end else begin
          e = exp_q.pop_front();
          if (pp_o !== e.pp) begin
            miscompares++;
            $display("FAIL pp_set: got %h, required %h", pp_o, e.pp);
          end
          vectors++;
          if (wsum(pp_o) != e.prod) begin
            miscompares++;
            $display("FAIL wsum: got %0d, required %0d", wsum(pp_o), e.prod);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        e.pp   = model_pp(x_i, y_i);
        e.prod = longint'($signed(x_i)) * longint'($signed(y_i));
        exp_q.push_back(e);
      end
      stall_v  = out_valid & ~out_ready;
      stall_pp = pp_o;
    end
  end

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge sys_clk); #1;
    end
    vectors++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d results outstanding, out_valid=%b; required 0 and 0", name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(16'h0000, 16'h0000);
    #2 sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pp_o !== 144'd0) begin
      miscompares++;
      $display("FAIL reset: out_valid=%b in_ready=%b pp_o=%h, required 0 1 0", out_valid, in_ready, pp_o);
    end
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_basic();
    in_valid = 1'b1;
    drive(16'd3, 16'd5);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || pp_o[17:0] !== 18'h00003 || pp_o[35:18] !== 18'h00003 || pp_o[143:36] !== 108'd0) begin
      miscompares++;
      $display("FAIL basic: out_valid=%b pp_o=%h, required 1 with pp0=pp1=3, rest 0", out_valid, pp_o);
    end
    drain("basic");
  endtask

  task automatic test_corner();
    in_valid = 1'b1;
    drive(16'h8000, 16'h8000);
    @(posedge sys_clk); #1;
    drive(16'h8000, 16'h7FFF);
    vectors++;
    if (inv_x_i !== 17'h08000 || pp_o[125:0] !== 126'd0 || pp_o[143:126] !== 18'h10000) begin
      miscompares++;
      $display("FAIL corner_min: pp_o=%h, required pp7=10000 and others 0", pp_o);
    end
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (wsum(pp_o) != -64'sd1073709056) begin
      miscompares++;
      $display("FAIL corner_sum: got %0d, required -1073709056", wsum(pp_o));
    end
    drain("corner");
  endtask

  task automatic test_skid();
    logic [143:0] pa;
    logic [143:0] pb;
    pa = model_pp(16'h1234, 16'hBEEF);
    pb = model_pp(16'hF00D, 16'h0777);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(16'h1234, 16'hBEEF);
    @(posedge sys_clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL skid_ready_a: in_ready=%b, required 1", in_ready);
    end
    drive(16'hF00D, 16'h0777);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || pp_o !== pa) begin
      miscompares++;
      $display("FAIL skid_full: in_ready=%b out_valid=%b pp_o=%h, required 0 1 %h", in_ready, out_valid, pp_o, pa);
    end
    repeat (3) @(posedge sys_clk);
    #1;
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || pp_o !== pb) begin
      miscompares++;
      $display("FAIL skid_move: in_ready=%b out_valid=%b pp_o=%h, required 1 1 %h", in_ready, out_valid, pp_o, pb);
    end
    @(posedge sys_clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL skid_empty: out_valid=%b, required 0", out_valid);
    end
    drain("skid");
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(16'($urandom), 16'($urandom));
    for (int i = 0; i < 1000; i++) begin
      @(posedge sys_clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_rate: cycle %0d out_valid=%b in_ready=%b, required 1 1", i, out_valid, in_ready);
      end
      drive(16'($urandom), 16'($urandom));
    end
    drain("stream");
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      drive(16'($urandom), 16'($urandom));
      @(posedge sys_clk); #1;
    end
    drain("random");
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(16'h7FFF, 16'h7FFF);
    @(posedge sys_clk); #1;
    drive(16'h8000, 16'h0001);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pp_o !== 144'd0) begin
      miscompares++;
      $display("FAIL reset_full: out_valid=%b in_ready=%b pp_o=%h, required 0 1 0", out_valid, in_ready, pp_o);
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(16'(i * 16'd311 + 16'd7), 16'(16'hFFFF - i));
      @(posedge sys_clk); #1;
    end
    drain("reset_full");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_corner();
    test_skid();
    test_stream();
    test_random();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth4_pp_stage.md
Name: booth4_pp_stage

Overview:
- Registered radix-4 Booth encoder and partial-product generator for the signed 16x16 multiplier.
- Sits directly downstream of inv_converter_16. It consumes the multiplicand X, its exact 17-bit negation -X and the multiplier Y, and produces 8 signed 18-bit partial products for the Wallace tree.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the upstream-facing ready is registered and full throughput is sustained.

Parameters:
- PP_W, 18, width of each partial product (signed two's complement).
- PP_N, 8, number of partial products (16-bit multiplier / 2).

Ports:
- sys_clk  input  1  clock, all state on the rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a valid operand set.
- in_ready  output  1  stage can accept; registered.
- x_i  input  16  multiplicand X, two's complement.
- inv_x_i  input  17  -X as a 17-bit two's complement value, driven by inv_converter_16 from x_i.
- y_i  input  16  multiplier Y, two's complement.
- out_valid  output  1  pp_o holds a valid set.
- out_ready  input  1  downstream accepts.
- pp_o  output  144  pp k occupies bits [18k+17:18k]; weight of pp k is 4^k.

Behaviour:
- Reset (async, sys_rst_n=0):
  - out_valid=0, in_ready=1, pp_o=0.
  - Skid entry cleared.
  - Reset mid-transfer discards all held data; no partial set is ever emitted afterwards.
- Booth encoding, group k=0..7:
  - Triplet is (y[2k+1], y[2k], y[2k-1]), with y[-1]=0.
  - Triplet mapping:
    - 000 or 111 -> 0.
    - 001 or 010 -> +X.
    - 011 -> +2X.
    - 100 -> -2X.
    - 101 or 110 -> -X.
- Width rules (all terms are 18-bit signed):
  - +X = sign-extend x_i to 18 bits.
  - +2X = sign-extend {x_i,0}.
  - -X = sign-extend inv_x_i.
  - -2X = {inv_x_i,0}.
  - No +1 correction term: inv_x_i is already exact, including x_i=16'h8000 -> inv_x_i=17'h08000 -> -2X=18'h10000.
- Correctness invariant: sum over k of pp_k * 4^k == x_i * y_i as signed 32-bit.
- Handshake:
  - Transfer on in_valid&in_ready (input side) and on out_valid&out_ready (output side).
  - Partial products are computed combinationally from the accepted inputs and registered.
  - Latency is 1 cycle from input transfer to out_valid, when the output is not stalled.
- Pipeline register: main output register plus one skid register.
- Input acceptance:
  - Main empty or draining this cycle -> data goes to the main register.
  - Main full and out_ready=0 -> data goes to the skid register, and in_ready drops next cycle.
- Skid full:
  - in_ready=0.
  - On an output transfer, skid moves to main, and in_ready=1 next cycle.
- Simultaneous accept and drain with skid empty: main reloads with the new data, out_valid stays 1, and there is no bubble.
- Ordering: strict FIFO order. No data loss or duplication under any out_ready pattern.
- pp_o and out_valid hold stable while out_valid=1 and out_ready=0.
- in_valid may drop without a transfer; x_i/y_i/inv_x_i are sampled only on a transfer.
- When out_valid=0, pp_o value is don't-care but must not be X after reset (stays 0 until the first load).

Test Plan:
- Basic encode:
  - x_i=3, inv_x_i=17'h1FFFD, y_i=5, out_ready=1 -> one cycle later out_valid=1.
  - pp0=18'h00003, pp1=18'h00003, pp2..pp7=0; weighted sum is 15.
- Corner operands:
  - x_i=16'h8000, inv_x_i=17'h08000, y_i=16'h8000 -> pp0..pp6=0, pp7=18'h10000; weighted sum is 2^30.
  - x_i=16'h8000, y_i=16'h7FFF -> weighted sum is -1073709056.
- Backpressure and skid:
  - out_ready=0, send A then B on consecutive cycles -> in_ready=0 from the cycle after B is accepted.
  - pp_o holds A. Raise out_ready -> A then B on consecutive cycles, then in_ready=1.
- Streaming: 1000 random (x,y) pairs, in_valid always 1, out_ready=1 -> one result per cycle after the first, every weighted sum equals x*y.
- Random out_ready at 50% and random in_valid -> in-order results, none lost or duplicated, pp_o stable while stalled.
- Reset with both registers full: assert sys_rst_n=0 asynchronously -> out_valid=0, in_ready=1, pp_o=0 immediately. After release, only newly sent data appears.
